// File: rtl/spa_pkg.sv
// Shared widths, FSM state type and accumulate helper for spectrum_power_accum.
// Build option SPA_SATURATE_EN selects saturating (defined) or wrapping (undefined) accumulation.
package spa_pkg;

    localparam int unsigned DIN_W = 18;
    localparam int unsigned ACC_W = 48;
    // Both inputs at -2^(DIN_W-1) give a power of exactly 2^(2*DIN_W-1), which needs the top bit.
    localparam int unsigned PWR_W = 2 * DIN_W;

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;

    typedef logic [PWR_W-1:0] pwr_t;
    typedef logic [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic sat;
        acc_t sum;
    } acc_res_t;

    function automatic acc_res_t sat_add(input acc_t acc, input pwr_t pwr);
        logic [ACC_W:0] full;
        acc_res_t       res;
        full = {1'b0, acc} + (ACC_W + 1)'(pwr);
`ifdef SPA_SATURATE_EN
        res.sat = full[ACC_W];
        res.sum = full[ACC_W] ? '1 : full[ACC_W-1:0];
`else
        res.sat = 1'b0;
        res.sum = full[ACC_W-1:0];
`endif
        return res;
    endfunction

endpackage

// File: rtl/spa_acc_ram.sv
// Simple dual-port accumulator RAM: one write port, one read port with 1-cycle registered read.
// No reset on the array; contents survive a block reset.
module spa_acc_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 48,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_power_accum.sv
// Integrates |X|^2 per FFT bin over acc_len spectra with a fixed 3-stage pipeline.
// Build option SPA_SATURATE_EN: clamp overflowing sums to all-ones and raise sat_flag.
module spectrum_power_accum #(
    parameter int unsigned BITWIDTH  = 7,
    parameter int unsigned FFT_POINT = 512,
    parameter int unsigned DIN_W     = 18,
    parameter int unsigned ACC_W     = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_in,
    input  logic [BITWIDTH+1:0]     cnt_in,
    input  logic signed [DIN_W-1:0] re_in,
    input  logic signed [DIN_W-1:0] im_in,
    input  logic [15:0]             acc_len,
    output logic [ACC_W-1:0]        para_out,
    output logic                    en_sync_out,
    output logic [BITWIDTH+1:0]     cnt_sync_out,
    output logic                    acc_done,
    output logic                    sat_flag
);

    import spa_pkg::*;

    localparam int unsigned IW     = BITWIDTH + 2;
    localparam int unsigned RAM_AW = $clog2(FFT_POINT);
    localparam logic [IW-1:0] LAST_BIN = IW'(FFT_POINT - 1);

    state_t      state_q, state_d;
    logic [15:0] pass_q, pass_d;
    logic [15:0] len_q, len_d;
    logic        start, wrap, in_range, accept, bin_first, bin_last;

    logic signed [2*DIN_W-1:0] re_ext, im_ext, re_prod, im_prod;

    logic          s1_vld, s1_first, s1_last;
    logic [IW-1:0] s1_idx;
    pwr_t          s1_re_sq, s1_im_sq;

    logic          s2_vld, s2_first, s2_last;
    logic [IW-1:0] s2_idx;
    pwr_t          s2_pwr;

    acc_t     ram_rdata, acc_base;
    acc_res_t res;
    logic     ram_we;

    assign re_ext  = {{DIN_W{re_in[DIN_W-1]}}, re_in};
    assign im_ext  = {{DIN_W{im_in[DIN_W-1]}}, im_in};
    assign re_prod = re_ext * re_ext;
    assign im_prod = im_ext * im_ext;

    assign in_range = ({1'b0, cnt_in} < (IW + 1)'(FFT_POINT));

    // Pass tracking: bin 0 opens a pass; the length is only re-sampled when a pass 0 begins.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        len_d   = len_q;
        start   = en_in && (cnt_in == '0);
        wrap    = (state_q == IDLE) || (pass_q == len_q - 16'd1);
        if (start) begin
            state_d = ACCUM;
            if (wrap) begin
                pass_d = '0;
                len_d  = (acc_len == 16'd0) ? 16'd1 : acc_len;
            end else begin
                pass_d = pass_q + 16'd1;
            end
        end
        accept    = en_in && in_range && (state_d == ACCUM);
        bin_first = (pass_d == '0);
        bin_last  = (pass_d == len_d - 16'd1);
    end

    // First pass ignores whatever the RAM holds, so it never needs clearing.
    always_comb begin
        acc_base = s2_first ? '0 : ram_rdata;
        res      = sat_add(acc_base, s2_pwr);
        ram_we   = s2_vld && !rst;
    end

    spa_acc_ram #(
        .DEPTH (FFT_POINT),
        .WIDTH (ACC_W),
        .AW    (RAM_AW)
    ) u_acc_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (s2_idx[RAM_AW-1:0]),
        .wdata (res.sum),
        .raddr (s1_idx[RAM_AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pass_q       <= '0;
            len_q        <= 16'd1;
            s1_vld       <= 1'b0;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
            s1_idx       <= '0;
            s1_re_sq     <= '0;
            s1_im_sq     <= '0;
            s2_vld       <= 1'b0;
            s2_first     <= 1'b0;
            s2_last      <= 1'b0;
            s2_idx       <= '0;
            s2_pwr       <= '0;
            para_out     <= '0;
            en_sync_out  <= 1'b0;
            cnt_sync_out <= '0;
            acc_done     <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            len_q    <= len_d;

            s1_vld   <= accept;
            s1_first <= bin_first;
            s1_last  <= bin_last;
            s1_idx   <= cnt_in;
            s1_re_sq <= pwr_t'(re_prod);
            s1_im_sq <= pwr_t'(im_prod);

            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
            s2_pwr   <= s1_re_sq + s1_im_sq;

            en_sync_out <= s2_vld && s2_last;
            acc_done    <= s2_vld && s2_last && (s2_idx == LAST_BIN);
            sat_flag    <= s2_vld && s2_last && res.sat;
            if (s2_vld && s2_last) begin
                para_out     <= res.sum;
                cnt_sync_out <= s2_idx;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_power_accum.sv
// Self-checking bench for spectrum_power_accum against a per-bin integration model.
// Runs with a reduced 8-bin spectrum and a 4-bit index so out-of-range bins can be exercised.
module tb_spectrum_power_accum;

    localparam int unsigned BW = 2;
    localparam int          FP = 8;
    localparam int unsigned IW = BW + 2;
    localparam int unsigned DW = 18;
    localparam int unsigned AW = 48;
    localparam longint TWO48 = 64'h0001_0000_0000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_in;
    logic [IW-1:0]        cnt_in;
    logic signed [DW-1:0] re_in;
    logic signed [DW-1:0] im_in;
    logic [15:0]          acc_len;
    logic [AW-1:0]        para_out;
    logic                 en_sync_out;
    logic [IW-1:0]        cnt_sync_out;
    logic                 acc_done;
    logic                 sat_flag;

    spectrum_power_accum #(
        .BITWIDTH  (BW),
        .FFT_POINT (FP),
        .DIN_W     (DW),
        .ACC_W     (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_in        (en_in),
        .cnt_in       (cnt_in),
        .re_in        (re_in),
        .im_in        (im_in),
        .acc_len      (acc_len),
        .para_out     (para_out),
        .en_sync_out  (en_sync_out),
        .cnt_sync_out (cnt_sync_out),
        .acc_done     (acc_done),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     vld;
        bit     done;
        bit     sat;
        longint val;
        int     idx;
    } exp_t;

    exp_t   pipe[$];
    longint mem_m [FP];
    bit     m_idle;
    int     m_pass;
    int     m_len;
    longint hold_para;
    int     hold_cnt;
    int     checks = 0;
    int     failures = 0;
    int     outs_seen = 0;
    int     done_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: integrate power per bin, pass/length rules applied directly on bin-0 arrivals.
    task automatic model_step(input bit en, input int cnt, input int re, input int im);
        exp_t   e;
        longint pwr;
        longint s;
        bit     sat;
        e.vld = 0; e.done = 0; e.sat = 0; e.val = 0; e.idx = 0;
        sat = 0;
        if (en && cnt == 0) begin
            if (m_idle || m_pass == m_len - 1) begin
                m_idle = 0;
                m_pass = 0;
                m_len  = (acc_len == 16'd0) ? 1 : int'(acc_len);
            end else begin
                m_pass++;
            end
        end
        if (en && cnt < FP && !m_idle) begin
            pwr = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            s = ((m_pass == 0) ? 64'sd0 : mem_m[cnt]) + pwr;
            if (s >= TWO48) begin
`ifdef SPA_SATURATE_EN
                s   = TWO48 - 1;
                sat = 1;
`else
                s = s - TWO48;
`endif
            end
            mem_m[cnt] = s;
            if (m_pass == m_len - 1) begin
                e.vld  = 1;
                e.val  = s;
                e.idx  = cnt;
                e.done = (cnt == FP - 1);
                e.sat  = sat;
            end
        end
        pipe.push_back(e);
    endtask

    task automatic cycle(input bit en, input int cnt, input int re, input int im);
        exp_t e;
        en_in  = en;
        cnt_in = IW'(cnt);
        re_in  = DW'(re);
        im_in  = DW'(im);
        model_step(en, cnt, re, im);
        @(posedge clk);
        #1;
        if (en_sync_out) outs_seen++;
        if (acc_done) done_seen++;
        if (pipe.size() >= 3) begin
            e = pipe.pop_front();
            if (e.vld) begin
                hold_para = e.val;
                hold_cnt  = e.idx;
            end
            chk("en_sync_out", 64'(en_sync_out), 64'(e.vld));
            chk("para_out", 64'(para_out), 64'(hold_para));
            chk("cnt_sync_out", 64'(cnt_sync_out), 64'(hold_cnt));
            chk("acc_done", 64'(acc_done), 64'(e.done));
            chk("sat_flag", 64'(sat_flag), 64'(e.sat));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 0, 0);
    endtask

    function automatic int rnd_val();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    // gap < 0 picks a random 0..2 idle cycles after each bin.
    task automatic frame(input int nbins, input bit rnd, input int re, input int im, input int gap);
        for (int b = 0; b < nbins; b++) begin
            int r;
            int i;
            int g;
            r = rnd ? rnd_val() : re;
            i = rnd ? rnd_val() : im;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            cycle(1'b1, b, r, i);
            repeat (g) cycle(1'b0, 0, 0, 0);
        end
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        en_in  = 1'b0;
        cnt_in = '0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_para_out", 64'(para_out), 64'd0);
        chk("rst_en_sync_out", 64'(en_sync_out), 64'd0);
        chk("rst_cnt_sync_out", 64'(cnt_sync_out), 64'd0);
        chk("rst_acc_done", 64'(acc_done), 64'd0);
        chk("rst_sat_flag", 64'(sat_flag), 64'd0);
        rst       = 1'b0;
        m_idle    = 1;
        m_pass    = 0;
        m_len     = 1;
        hold_para = 0;
        hold_cnt  = 0;
        pipe.delete();
        idle_entry();
        idle_entry();
    endtask

    task automatic idle_entry();
        exp_t e;
        e.vld = 0; e.done = 0; e.sat = 0; e.val = 0; e.idx = 0;
        pipe.push_back(e);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0;
        int d0;
        rst     = 1'b1;
        en_in   = 1'b0;
        cnt_in  = '0;
        re_in   = '0;
        im_in   = '0;
        acc_len = 16'd1;
        for (int k = 0; k < FP; k++) mem_m[k] = 0;
        do_reset(2);

        // Non-zero bins while idle must be ignored.
        o0 = outs_seen;
        for (int c = 1; c < FP; c++) cycle(1'b1, c, 5, 5);
        cycle(1'b1, 10, 5, 5);
        idle(4);
        chk("idle_ignored_count", 64'(outs_seen - o0), 64'd0);

        // T1: single-pass integration.
        acc_len = 16'd1;
        o0 = outs_seen; d0 = done_seen;
        frame(FP, 1'b0, 3, 4, 0);
        idle(4);
        chk("t1_count", 64'(outs_seen - o0), 64'(FP));
        chk("t1_done", 64'(done_seen - d0), 64'd1);
        chk("t1_value", 64'(para_out), 64'd25);

        // T2: four passes, output only on the last.
        acc_len = 16'd4;
        o0 = outs_seen; d0 = done_seen;
        repeat (3) frame(FP, 1'b0, -2, 1, 0);
        idle(3);
        chk("t2_early_count", 64'(outs_seen - o0), 64'd0);
        frame(FP, 1'b0, -2, 1, 0);
        idle(4);
        chk("t2_count", 64'(outs_seen - o0), 64'(FP));
        chk("t2_done", 64'(done_seen - d0), 64'd1);
        chk("t2_value", 64'(para_out), 64'd20);

        // T4: input gaps of two cycles between bins.
        acc_len = 16'd2;
        o0 = outs_seen;
        repeat (2) frame(FP, 1'b0, 1, 1, 2);
        idle(4);
        chk("t4_count", 64'(outs_seen - o0), 64'(FP));
        chk("t4_value", 64'(para_out), 64'd4);

        // acc_len of zero behaves as one.
        acc_len = 16'd0;
        o0 = outs_seen;
        frame(FP, 1'b1, 0, 0, -1);
        idle(4);
        chk("len0_count", 64'(outs_seen - o0), 64'(FP));

        // Random data and gaps over three passes.
        acc_len = 16'd3;
        o0 = outs_seen;
        repeat (3) frame(FP, 1'b1, 0, 0, -1);
        idle(4);
        chk("rand_count", 64'(outs_seen - o0), 64'(FP));

        // T5: length change mid-integration applies to the next integration only.
        acc_len = 16'd4;
        o0 = outs_seen;
        frame(FP, 1'b0, 7, -3, 0);
        acc_len = 16'd2;
        repeat (2) frame(FP, 1'b0, 7, -3, 0);
        idle(3);
        chk("t5_early_count", 64'(outs_seen - o0), 64'd0);
        frame(FP, 1'b0, 7, -3, 0);
        idle(4);
        chk("t5_first_count", 64'(outs_seen - o0), 64'(FP));
        chk("t5_first_value", 64'(para_out), 64'd232);
        o0 = outs_seen;
        repeat (2) frame(FP, 1'b0, 7, -3, 0);
        idle(4);
        chk("t5_second_count", 64'(outs_seen - o0), 64'(FP));
        chk("t5_second_value", 64'(para_out), 64'd116);

        // Short final pass with out-of-range indices interleaved.
        acc_len = 16'd2;
        frame(FP, 1'b1, 0, 0, 0);
        o0 = outs_seen; d0 = done_seen;
        cycle(1'b1, 0, rnd_val(), rnd_val());
        cycle(1'b1, 12, rnd_val(), rnd_val());
        cycle(1'b1, 1, rnd_val(), rnd_val());
        cycle(1'b1, 2, rnd_val(), rnd_val());
        cycle(1'b1, 15, rnd_val(), rnd_val());
        cycle(1'b1, 3, rnd_val(), rnd_val());
        idle(4);
        chk("short_count", 64'(outs_seen - o0), 64'd4);
        chk("short_done", 64'(done_seen - d0), 64'd0);
        o0 = outs_seen;
        repeat (2) frame(FP, 1'b1, 0, 0, -1);
        idle(4);
        chk("after_short_count", 64'(outs_seen - o0), 64'(FP));

        // T6: reset in pass 2 of 4, then resume mid-spectrum.
        acc_len = 16'd4;
        o0 = outs_seen;
        repeat (2) frame(FP, 1'b0, 10, 20, 0);
        frame(3, 1'b0, 10, 20, 0);
        do_reset(1);
        for (int c = 5; c < FP; c++) cycle(1'b1, c, 10, 20);
        idle(3);
        chk("t6_ignored_count", 64'(outs_seen - o0), 64'd0);
        repeat (4) frame(FP, 1'b0, 10, 20, 0);
        idle(4);
        chk("t6_count", 64'(outs_seen - o0), 64'(FP));
        chk("t6_value", 64'(para_out), 64'd2000);

        // T3: 8192 passes of the largest power reach exactly 2^48.
        acc_len = 16'd8192;
        o0 = outs_seen; d0 = done_seen;
        repeat (8192) frame(FP, 1'b0, -131072, -131072, 0);
        idle(4);
        chk("t3_count", 64'(outs_seen - o0), 64'(FP));
        chk("t3_done", 64'(done_seen - d0), 64'd1);
`ifdef SPA_SATURATE_EN
        chk("t3_value", 64'(para_out), 64'h0000_FFFF_FFFF_FFFF);
`else
        chk("t3_value", 64'(para_out), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
